perm_slide_engine: RTL

- Sequential vector slide unit in the permutation path.
- Executes vslideup, vslidedown, vslide1up and vslide1down on one register group of VLMAX elements, producing one destination element per cycle.
- For each destination index it finds the source element using add-comparator equality checks (j+off == i for slide-up, i+off == j for slide-down).
- It feeds those comparators and consumes their match vectors.
- Results go to the vector writeback stage through a valid/ready handshake.

---
 rtl/perm_slide_engine.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/perm_slide_engine.sv
// Sequential vector slide unit: vslideup/vslidedown/vslide1up/vslide1down,
// one destination element per cycle, result returned over a valid/ready handshake.
module perm_slide_engine #(
  parameter int unsigned VLMAX = 8,
  parameter int unsigned DW    = 32,
  parameter int unsigned OFFW  = 32,
  localparam int unsigned IW   = $clog2(VLMAX),
  localparam int unsigned VLW  = IW + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [1:0]          op_i,
  input  logic [OFFW-1:0]     off_i,
  input  logic [VLW-1:0]      vl_i,
  input  logic [DW-1:0]       scalar_i,
  input  logic [VLMAX*DW-1:0] src_i,
  input  logic [VLMAX*DW-1:0] vd_i,
  input  logic                flush_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [VLMAX*DW-1:0] res_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [OFFW-1:0]     off_q, off_d;
  logic [VLW-1:0]      vl_q, vl_d;
  logic [DW-1:0]       scalar_q, scalar_d;
  logic [VLMAX*DW-1:0] src_q, src_d;
  logic [VLMAX*DW-1:0] res_q, res_d;
  logic [IW-1:0]       cnt_q, cnt_d;

  logic [OFFW-1:0]  eff_off;
  logic [OFFW-1:0]  idx;
  logic             off_ok;
  logic             slide_down;
  logic [VLMAX-1:0] hit;
  logic [DW-1:0]    sel_elem;
  logic [DW-1:0]    new_elem;
  logic             last;

  // Add-comparator match: offsets >= VLMAX can never hit, which also blocks
  // modulo-2^OFFW wraparound in the sums.
  always_comb begin
    eff_off    = op_q[1] ? OFFW'(1) : off_q;
    off_ok     = eff_off < OFFW'(VLMAX);
    slide_down = op_q[0];
    idx        = OFFW'(cnt_q);
    hit        = '0;
    for (int j = 0; j < VLMAX; j++) begin
      if (slide_down) begin
        hit[j] = off_ok && ((idx + eff_off) == OFFW'(j));
      end else begin
        hit[j] = off_ok && ((OFFW'(j) + eff_off) == idx);
      end
    end
  end

  always_comb begin
    sel_elem = '0;
    for (int j = 0; j < VLMAX; j++) begin
      if (hit[j]) begin
        sel_elem = sel_elem | src_q[j*DW +: DW];
      end
    end
  end

  always_comb begin
    last = (VLW'(cnt_q) == (vl_q - VLW'(1)));
    if (op_q == 2'b10 && cnt_q == '0) begin
      new_elem = scalar_q;
    end else if (op_q == 2'b11 && last) begin
      new_elem = scalar_q;
    end else if (hit != '0) begin
      new_elem = sel_elem;
    end else if (slide_down) begin
      new_elem = '0;
    end else begin
      // res_q still holds vd at this index
      new_elem = res_q[cnt_q*DW +: DW];
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    off_d    = off_q;
    vl_d     = vl_q;
    scalar_d = scalar_q;
    src_d    = src_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    ready_o  = (state_q == StIdle);
    valid_o  = (state_q == StDone);

    unique case (state_q)
      StIdle: begin
        if (valid_i && !flush_i) begin
          op_d     = op_i;
          off_d    = off_i;
          vl_d     = vl_i;
          scalar_d = scalar_i;
          src_d    = src_i;
          res_d    = vd_i;
          cnt_d    = '0;
          state_d  = (vl_i != '0) ? StRun : StDone;
        end
      end
      StRun: begin
        res_d[cnt_q*DW +: DW] = new_elem;
        cnt_d = cnt_q + IW'(1);
        if (last) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush_i) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      off_q    <= '0;
      vl_q     <= '0;
      scalar_q <= '0;
      src_q    <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      off_q    <= off_d;
      vl_q     <= vl_d;
      scalar_q <= scalar_d;
      src_q    <= src_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
    end
  end

  assign res_o = res_q;

  // At most one source index may match a destination index.
  a_onehot_match: assert property (@(posedge clk) disable iff (rst)
    (state_q == StRun) |-> $onehot0(hit));

endmodule
